// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state encoding and default parameters for the run sequencer,
// shared by run_ctrl, its interface, top_level and the bench.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DONE,
        ERR
    } run_state_t;

    localparam int unsigned D_DEF       = 12;
    localparam int unsigned CW_DEF      = 16;
    localparam int unsigned HALT_PC_DEF = 128;
    localparam int unsigned RST_CYC_DEF = 2;
    localparam int unsigned MAX_CYC_DEF = 32'h0000_FFF0;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: harness <-> run sequencer signals. The harness is the master
// (drives req, forwards the core PC); run_ctrl is the slave.
import run_ctrl_pkg::*;

interface run_ctrl_if #(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned CW = CW_DEF
);
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output req, prog_ctr,
        input  core_rst, core_en, busy, done, timeout, cycle_cnt
    );

    modport slave (
        input  req, prog_ctr,
        output core_rst, core_en, busy, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones.
import run_ctrl_pkg::*;

module sat_counter #(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt
);
    logic [CW-1:0] r_cnt;

    // Count register: clear has priority over increment; hold at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: turns the harness req/done handshake into core reset/enable,
// detects the halt PC and counts RUN cycles.
// Optional RUN_CTRL_TIMEOUT_EN: aborts a run after MAX_CYC RUN cycles
// (ERR state, timeout=1). Without it timeout is tied low.
import run_ctrl_pkg::*;

module run_ctrl #(
    parameter int unsigned D       = D_DEF,
    parameter int unsigned HALT_PC = HALT_PC_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned MAX_CYC = MAX_CYC_DEF
) (
    input logic         clk,
    input logic         reset,
    run_ctrl_if.slave   bus
);
    localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_t     r_state;
    run_state_t     w_state_nxt;
    logic           r_req_q;
    logic [RCW-1:0] r_rst_cnt;
    logic [RCW-1:0] w_rst_cnt_nxt;
    logic           w_req_rise;
    logic           w_halt;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic [CW-1:0]  w_cycle_cnt;

    assign w_req_rise = bus.req & ~r_req_q;
    assign w_halt     = (bus.prog_ctr == D'(HALT_PC));

`ifdef RUN_CTRL_TIMEOUT_EN
    logic w_at_limit;
    assign w_at_limit = (w_cycle_cnt == CW'(MAX_CYC - 1));
`else
    logic w_unused_limit;
    assign w_unused_limit = (MAX_CYC != 0);
`endif

    // State, request edge history and reset-hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req_q   <= 1'b0;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= bus.req;
            r_rst_cnt <= w_rst_cnt_nxt;
        end
    end

    // Next-state logic plus cycle counter clear/increment requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_req_rise) begin
                    w_state_nxt   = RST;
                    w_rst_cnt_nxt = RCW'(RST_CYC - 1);
                    w_cnt_clr     = 1'b1;
                end
            end
            RST: begin
                if (r_rst_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - RCW'(1);
                end
            end
            RUN: begin
                w_cnt_inc = 1'b1;
                if (w_halt) begin
                    w_state_nxt = DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
                end else if (w_at_limit) begin
                    w_state_nxt = ERR;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        bus.core_rst = 1'b0;
        bus.core_en  = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.timeout  = 1'b0;
        case (r_state)
            IDLE: bus.core_rst = 1'b1;
            RST: begin
                bus.core_rst = 1'b1;
                bus.busy     = 1'b1;
            end
            RUN: begin
                bus.core_en = 1'b1;
                bus.busy    = 1'b1;
            end
            DONE: bus.done = 1'b1;
            ERR: begin
                bus.done = 1'b1;
`ifdef RUN_CTRL_TIMEOUT_EN
                bus.timeout = 1'b1;
`endif
            end
            default: bus.core_rst = 1'b1;
        endcase
    end

    sat_counter #(.CW(CW)) u_cycle_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cycle_cnt)
    );

    assign bus.cycle_cnt = w_cycle_cnt;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. Instance A uses CW=16, MAX_CYC=20;
// instance B uses CW=8 to reach counter saturation / limit quickly.
import run_ctrl_pkg::*;

module tb_run_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;
    int   en_cycles;

    run_ctrl_if #(.D(12), .CW(16)) if_a ();
    run_ctrl_if #(.D(12), .CW(8))  if_b ();

    run_ctrl #(
        .D(12), .HALT_PC(128), .RST_CYC(2), .CW(16), .MAX_CYC(20)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    run_ctrl #(
        .D(12), .HALT_PC(128), .RST_CYC(2), .CW(8), .MAX_CYC(255)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic e_rst, input logic e_en,
                            input logic e_busy, input logic e_done, input logic e_to,
                            input logic [15:0] e_cnt);
        chk({tag, ".core_rst"},  32'(if_a.core_rst),  32'(e_rst));
        chk({tag, ".core_en"},   32'(if_a.core_en),   32'(e_en));
        chk({tag, ".busy"},      32'(if_a.busy),      32'(e_busy));
        chk({tag, ".done"},      32'(if_a.done),      32'(e_done));
        chk({tag, ".timeout"},   32'(if_a.timeout),   32'(e_to));
        chk({tag, ".cycle_cnt"}, 32'(if_a.cycle_cnt), 32'(e_cnt));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        en_cycles   = 0;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        if_a.req      = 1'b0;
        if_a.prog_ctr = '0;
        if_b.req      = 1'b0;
        if_b.prog_ctr = '0;

        // 1: reset held three cycles
        repeat (3) tick();
        expect_a("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        expect_a("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // 2: req raised and held high; RST lasts two cycles
        if_a.req = 1'b1;
        tick();
        expect_a("rst1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        tick();
        expect_a("rst2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        tick();
        expect_a("run0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        if (if_a.core_en) en_cycles++;
        for (int i = 0; i < 10; i++) begin
            if_a.prog_ctr = 12'(i + 1);
            tick();
            if (if_a.core_en) en_cycles++;
        end
        chk("run10.cycle_cnt", 32'(if_a.cycle_cnt), 32'd10);
        chk("run10.busy", 32'(if_a.busy), 32'd1);
        if_a.prog_ctr = 12'd128;
        tick();
        if (if_a.core_en) en_cycles++;
        expect_a("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        chk("en_cycles", 32'(en_cycles), 32'd11);

        // 5: req still high in DONE does not restart; a fresh rise does
        if_a.prog_ctr = 12'd0;
        repeat (3) tick();
        expect_a("done_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        if_a.req = 1'b0;
        tick();
        expect_a("done_low", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        if_a.req = 1'b1;
        tick();
        expect_a("restart", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        if_a.req = 1'b0;
        repeat (2) tick();
        chk("restart.core_en", 32'(if_a.core_en), 32'd1);

        // 3: non-halting program (limit 20 with the feature, free run without)
        repeat (19) tick();
        expect_a("run19", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd19);
        tick();
`ifdef RUN_CTRL_TIMEOUT_EN
        expect_a("limit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20);
        tick();
        expect_a("err_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20);
`else
        expect_a("nolimit", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd20);
        repeat (5) tick();
        expect_a("nolimit25", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd25);
        if_a.prog_ctr = 12'd128;
        tick();
        expect_a("halt26", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd26);
        if_a.prog_ctr = 12'd0;
`endif

        // 4: halt on the 20th RUN edge beats the limit
        if_a.req = 1'b1;
        tick();
        expect_a("run4_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        if_a.req = 1'b0;
        repeat (2) tick();
        repeat (19) tick();
        chk("run4.cycle_cnt19", 32'(if_a.cycle_cnt), 32'd19);
        if_a.prog_ctr = 12'd128;
        tick();
        expect_a("halt_vs_limit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20);
        if_a.prog_ctr = 12'd0;

        // 6: asynchronous reset in the middle of RUN
        if_a.req = 1'b1;
        tick();
        if_a.req = 1'b0;
        repeat (2) tick();
        repeat (5) tick();
        expect_a("mid_run", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
        rst_a = 1'b1;
        #1;
        expect_a("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick();
        rst_a = 1'b0;
        tick();
        expect_a("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // 6b: CW=8 instance, no halt for 300 RUN edges
        if_b.req = 1'b1;
        tick();
        chk("b_rst.busy", 32'(if_b.busy), 32'd1);
        if_b.req = 1'b0;
        repeat (2) tick();
        chk("b_run.core_en", 32'(if_b.core_en), 32'd1);
        repeat (300) tick();
        chk("b_sat.cycle_cnt", 32'(if_b.cycle_cnt), 32'd255);
`ifdef RUN_CTRL_TIMEOUT_EN
        chk("b_sat.done", 32'(if_b.done), 32'd1);
        chk("b_sat.timeout", 32'(if_b.timeout), 32'd1);
`else
        chk("b_sat.busy", 32'(if_b.busy), 32'd1);
        chk("b_sat.timeout", 32'(if_b.timeout), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
